// File: rtl/demux1_4_sched.sv
// demux1_4_sched
//   Sequencer in front of the 1-to-4 structural demux. It takes one word
//   at a time from a valid/ready input and picks a channel, either
//   round-robin or from in_dest. It drives the demux selects S2/S1 and
//   holds the word on out_data until the chosen channel accepts it.
//   In round-robin mode, a channel that stalls for TIMEOUT cycles is
//   skipped, and the word moves on to the next channel.

module demux1_4_sched #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16          // 0 disables round-robin retargeting
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,         // 0 = round-robin, 1 = addressed
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    output logic          S2,
    output logic          S1,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic          busy,
    output logic [7:0]    skip_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // The stall counter only has to reach TIMEOUT-1. In addressed mode
    // the counter wraps harmlessly because that mode never times out.
    localparam int             WCW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;
    localparam logic           TO_EN     = (TIMEOUT != 0);

    state_t         state;
    logic [1:0]     target;
    logic [1:0]     rr_ptr;
    logic           mode_q;             // mode latched when the word is accepted
    logic [WCW-1:0] wait_cnt;

    logic [1:0]     accept_tgt;
    logic [1:0]     next_tgt;
    logic           target_ready;
    logic           timeout_hit;

    function automatic logic [3:0] onehot(input logic [1:0] ch);
        onehot = 4'b0001 << ch;
    endfunction

    // Decode the destination and the send-state events that drive the sequencer.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        accept_tgt   = rr_ptr;
        next_tgt     = target + 2'd1;
        target_ready = out_ready[target];
        timeout_hit  = 1'b0;
        if (mode) begin
            accept_tgt = in_dest;
        end
        if (!mode_q && TO_EN && (wait_cnt == WAIT_LAST)) begin
            timeout_hit = 1'b1;
        end
    end

    // Two-state sequencer: accept in IDLE, then hold and offer the word in SEND.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every read sees the pre-edge value.
        if (rst) begin
            state     <= IDLE;
            target    <= 2'd0;
            rr_ptr    <= 2'd0;
            mode_q    <= 1'b0;
            wait_cnt  <= '0;
            skip_cnt  <= 8'd0;
            out_valid <= 4'b0000;
            // NOTE: the held word is cleared on reset too, so out_data reads zero after reset.
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        target    <= accept_tgt;
                        out_valid <= onehot(accept_tgt);
                        mode_q    <= mode;
                        wait_cnt  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (target_ready) begin
                        // Transfer wins over a timeout that lands on the same edge.
                        out_valid <= 4'b0000;
                        state     <= IDLE;
                        if (!mode_q) begin
                            rr_ptr <= next_tgt;
                        end
                    end else if (timeout_hit) begin
                        target    <= next_tgt;
                        out_valid <= onehot(next_tgt);
                        wait_cnt  <= '0;
                        if (skip_cnt != 8'hFF) begin
                            skip_cnt <= skip_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 4'b0000;
                end
            endcase
        end
    end

    // Status and selects decoded from the registered state.
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        busy     = (state == SEND);
        S2       = target[1];
        S1       = target[0];
    end

endmodule

// File: tb/tb_demux1_4_sched.sv
// tb_demux1_4_sched
//   Directed bench for demux1_4_sched with TIMEOUT=4. It covers reset,
//   round-robin rotation, addressed routing, timeout retarget, a transfer
//   on the timeout edge, unbounded addressed stalls, reset during SEND,
//   and skip_cnt saturation.

module tb_demux1_4_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          S2;
    logic          S1;
    logic [DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          busy;
    logic [7:0]    skip_cnt;

    int total = 0;
    int bad   = 0;

    demux1_4_sched #(.DW(DW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .S2        (S2),
        .S1        (S1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one word for a single cycle. The accept edge is the tick here.
    task automatic offer(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [7:0] rr_data [5];
    logic [1:0] rr_ch   [5];

    initial begin
        rr_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        rr_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = 2'd0;
        out_ready = 4'b1111;

        // Reset state
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sel",       32'({S2, S1}), 32'h0);
        check("rst_in_ready",  32'(in_ready), 32'h0);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_skip",      32'(skip_cnt), 32'h0);
        check("rst_out_data",  32'(out_data), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Test 1: round-robin with every channel ready, 2 cycles per word
        for (int i = 0; i < 5; i++) begin
            offer(rr_data[i]);
            check("rr_valid",    32'(out_valid), 32'(4'b0001 << rr_ch[i]));
            check("rr_sel",      32'({S2, S1}), 32'(rr_ch[i]));
            check("rr_data",     32'(out_data), 32'(rr_data[i]));
            check("rr_in_ready", 32'(in_ready), 32'h0);
            check("rr_busy",     32'(busy), 32'h1);
            tick();
            check("rr_done_valid", 32'(out_valid), 32'h0);
            check("rr_done_ready", 32'(in_ready), 32'h1);
        end

        // Test 2: addressed to channel 2 from a fresh reset; rr_ptr must stay at 0
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        mode    = 1'b1;
        in_dest = 2'd2;
        offer(8'h5A);
        check("addr_valid", 32'(out_valid), 32'h4);
        check("addr_sel",   32'({S2, S1}), 32'h2);
        check("addr_data",  32'(out_data), 32'h5A);
        tick();
        check("addr_done", 32'(out_valid), 32'h0);
        mode = 1'b0;
        offer(8'h11);
        check("addr_rr_kept", 32'(out_valid), 32'h1);
        tick();                                   // rr_ptr now 1

        // Test 3: channel 1 stalls; after 4 stall cycles retarget to channel 2
        out_ready = 4'b1101;
        offer(8'h33);
        check("to_first", 32'(out_valid), 32'h2);
        tick(); tick(); tick();
        check("to_hold_valid", 32'(out_valid), 32'h2);
        check("to_hold_skip",  32'(skip_cnt), 32'h0);
        tick();
        check("to_retarget_valid", 32'(out_valid), 32'h4);
        check("to_retarget_sel",   32'({S2, S1}), 32'h2);
        check("to_retarget_skip",  32'(skip_cnt), 32'h1);
        check("to_retarget_data",  32'(out_data), 32'h33);
        tick();
        check("to_xfer_valid", 32'(out_valid), 32'h0);
        check("to_xfer_ready", 32'(in_ready), 32'h1);   // rr_ptr now 3

        // Test 6: ready rises on the timeout edge, so the transfer wins on channel 3
        out_ready = 4'b0111;
        offer(8'h66);
        check("edge_first", 32'(out_valid), 32'h8);
        tick(); tick(); tick();
        out_ready = 4'b1111;
        tick();
        check("edge_valid", 32'(out_valid), 32'h0);
        check("edge_skip",  32'(skip_cnt), 32'h1);
        check("edge_sel",   32'({S2, S1}), 32'h3);
        check("edge_ready", 32'(in_ready), 32'h1);     // rr_ptr now 0

        // Test 4: addressed to channel 3 while it is stalled for 50 cycles
        mode      = 1'b1;
        in_dest   = 2'd3;
        out_ready = 4'b0111;
        offer(8'h44);
        for (int i = 0; i < 50; i++) tick();
        check("addr_stall_valid", 32'(out_valid), 32'h8);
        check("addr_stall_sel",   32'({S2, S1}), 32'h3);
        check("addr_stall_skip",  32'(skip_cnt), 32'h1);
        check("addr_stall_busy",  32'(busy), 32'h1);
        out_ready = 4'b1111;
        tick();
        check("addr_stall_done",  32'(out_valid), 32'h0);
        check("addr_stall_ready", 32'(in_ready), 32'h1);
        mode = 1'b0;
        offer(8'h77);
        check("addr_stall_rr", 32'(out_valid), 32'h1); // rr_ptr untouched
        tick();                                   // rr_ptr now 1

        // Test 5: reset while a word is held
        out_ready = 4'b0000;
        offer(8'h88);
        check("rst_send_valid", 32'(out_valid), 32'h2);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_sel",   32'({S2, S1}), 32'h0);
        check("midrst_ready", 32'(in_ready), 32'h0);
        check("midrst_busy",  32'(busy), 32'h0);
        check("midrst_skip",  32'(skip_cnt), 32'h0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 32'(in_ready), 32'h1);
        out_ready = 4'b1111;
        offer(8'h99);
        check("midrst_rr0", 32'(out_valid), 32'h1);
        tick();                                   // rr_ptr now 1

        // Retarget wrap and skip_cnt saturation with every channel stalled
        out_ready = 4'b0000;
        offer(8'hC3);
        for (int i = 0; i < 12; i++) tick();
        check("wrap_valid", 32'(out_valid), 32'h1);    // 1 + 3 retargets wraps to 0
        check("wrap_skip",  32'(skip_cnt), 32'h3);
        for (int i = 0; i < 1012; i++) tick();
        check("sat_skip",  32'(skip_cnt), 32'hFF);
        check("sat_valid", 32'(out_valid), 32'h2);     // 256 retargets from ch1
        check("sat_data",  32'(out_data), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
